// File: rtl/glitc_config_ctrl_if.sv
// Register-bus bundle between the TISC host and the GLITC configuration sequencer.
// Member names follow the slave's view (_i into the sequencer, _o out of it).
interface glitc_config_ctrl_if;
  logic        cyc_i;
  logic        stb_i;
  logic        we_i;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic        ack_o;

  modport master (output cyc_i, stb_i, we_i, dat_i, input dat_o, ack_o);
  modport slave  (input cyc_i, stb_i, we_i, dat_i, output dat_o, ack_o);
endinterface

// File: rtl/glitc_config_ctrl.sv
// Configuration sequencer for the four GLITC FPGAs: PROGRAM_B/INIT_B pulses, DONE wait, gready.
// Optional macro GLITC_CFG_AUTORETRY_EN: one automatic reprogram after a LOAD timeout.
module glitc_config_ctrl #(
  parameter int unsigned PROG_CYCLES  = 64,
  parameter int unsigned INIT_CYCLES  = 32,
  parameter int unsigned TIMEOUT_BITS = 24
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  glitc_config_ctrl_if.slave        bus,
  input  logic [3:0]                done_i,
  input  logic [3:0]                init_b_i,
  output logic [3:0]                program_b_o,
  output logic [3:0]                init_b_oe_o,
  output logic [3:0]                gready_o
);

  localparam int unsigned N_CH   = 4;
  localparam int unsigned PROG_W = (PROG_CYCLES > 1) ? $clog2(PROG_CYCLES) : 1;
  localparam int unsigned INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam int unsigned PI_W   = (PROG_W > INIT_W) ? PROG_W : INIT_W;
  localparam int unsigned CNT_W  = (PI_W > TIMEOUT_BITS) ? PI_W : TIMEOUT_BITS;

  localparam logic [CNT_W-1:0] PROG_LOAD = CNT_W'(PROG_CYCLES - 1);
  localparam logic [CNT_W-1:0] INIT_LOAD = CNT_W'(INIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LOAD  = CNT_W'({TIMEOUT_BITS{1'b1}});

  typedef enum logic [2:0] {
    ST_UNCONF,
    ST_PROG,
    ST_INIT,
    ST_LOAD,
    ST_READY,
    ST_ERROR
  } state_t;

  logic            r_ack;
  logic            r_served;
  logic [31:0]     r_dat;
  logic [N_CH-1:0] r_wr_start;
  logic [N_CH-1:0] r_wr_abort;
  logic [N_CH-1:0] r_done_s1;
  logic [N_CH-1:0] r_done_s2;
  logic [N_CH-1:0] r_init_s1;
  logic [N_CH-1:0] r_init_s2;

  logic            w_req;
  logic [N_CH-1:0] w_busy;
  logic [N_CH-1:0] w_err;
  logic [N_CH-1:0] w_retry;
  logic            w_unused;

  // A request is served once; it re-arms only when cyc/stb drops.
  assign w_req    = bus.cyc_i && bus.stb_i && !r_served;
  assign w_unused = ^bus.dat_i[31:8];

  assign bus.ack_o = r_ack;
  assign bus.dat_o = r_dat;

  // Bus handshake, write-mask capture, pin synchronizers and status register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_ack      <= 1'b0;
      r_served   <= 1'b0;
      r_dat      <= 32'h0;
      r_wr_start <= '0;
      r_wr_abort <= '0;
      r_done_s1  <= '0;
      r_done_s2  <= '0;
      r_init_s1  <= '0;
      r_init_s2  <= '0;
    end else begin
      r_ack      <= w_req;
      r_served   <= bus.cyc_i && bus.stb_i;
      r_wr_start <= (w_req && bus.we_i) ? bus.dat_i[3:0] : 4'h0;
      r_wr_abort <= (w_req && bus.we_i) ? bus.dat_i[7:4] : 4'h0;
      r_done_s1  <= done_i;
      r_done_s2  <= r_done_s1;
      r_init_s1  <= init_b_i;
      r_init_s2  <= r_init_s1;
      r_dat      <= {8'h00, w_retry, r_init_s2, r_done_s2, w_err, w_busy, gready_o};
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    state_t           r_state;
    state_t           w_state_nx;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nx;
    logic             r_pb;
    logic             r_oe;
    logic             r_gr;
    logic             w_timeout;
`ifdef GLITC_CFG_AUTORETRY_EN
    logic             r_retry;
    logic             w_retry_nx;
`endif

    // Pin outputs are decoded from the next state so they move with the state register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        r_state <= ST_UNCONF;
        r_cnt   <= '0;
        r_pb    <= 1'b1;
        r_oe    <= 1'b0;
        r_gr    <= 1'b0;
`ifdef GLITC_CFG_AUTORETRY_EN
        r_retry <= 1'b0;
`endif
      end else begin
        r_state <= w_state_nx;
        r_cnt   <= w_cnt_nx;
        r_pb    <= (w_state_nx != ST_PROG);
        r_oe    <= (w_state_nx == ST_PROG) || (w_state_nx == ST_INIT);
        r_gr    <= (w_state_nx == ST_READY);
`ifdef GLITC_CFG_AUTORETRY_EN
        r_retry <= w_retry_nx;
`endif
      end
    end

    always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      w_timeout  = 1'b0;
`ifdef GLITC_CFG_AUTORETRY_EN
      w_retry_nx = r_retry;
`endif
      if (r_wr_abort[g]) begin
        w_state_nx = ST_UNCONF;
        w_cnt_nx   = '0;
`ifdef GLITC_CFG_AUTORETRY_EN
        w_retry_nx = 1'b0;
`endif
      end else if (r_wr_start[g]) begin
        w_state_nx = ST_PROG;
        w_cnt_nx   = PROG_LOAD;
`ifdef GLITC_CFG_AUTORETRY_EN
        w_retry_nx = 1'b0;
`endif
      end else begin
        case (r_state)
          ST_PROG: begin
            if (r_cnt == '0) begin
              w_state_nx = ST_INIT;
              w_cnt_nx   = INIT_LOAD;
            end else begin
              w_cnt_nx = r_cnt - CNT_W'(1);
            end
          end
          ST_INIT: begin
            if (r_cnt == '0) begin
              w_state_nx = ST_LOAD;
              w_cnt_nx   = TMO_LOAD;
            end else begin
              w_cnt_nx = r_cnt - CNT_W'(1);
            end
          end
          // DONE is checked ahead of the timeout so a coincident DONE wins.
          ST_LOAD: begin
            if (r_done_s2[g]) begin
              w_state_nx = ST_READY;
            end else if (r_cnt <= CNT_W'(1)) begin
              w_timeout = 1'b1;
            end else begin
              w_cnt_nx = r_cnt - CNT_W'(1);
            end
          end
          ST_READY: begin
            if (!r_done_s2[g]) begin
              w_state_nx = ST_ERROR;
            end
          end
          default: ;
        endcase
        if (w_timeout) begin
`ifdef GLITC_CFG_AUTORETRY_EN
          if (!r_retry) begin
            w_state_nx = ST_PROG;
            w_cnt_nx   = PROG_LOAD;
            w_retry_nx = 1'b1;
          end else begin
            w_state_nx = ST_ERROR;
          end
`else
          w_state_nx = ST_ERROR;
`endif
        end
      end
    end

    assign program_b_o[g] = r_pb;
    assign init_b_oe_o[g] = r_oe;
    assign gready_o[g]    = r_gr;
    assign w_busy[g]      = (r_state == ST_PROG) || (r_state == ST_INIT) || (r_state == ST_LOAD);
    assign w_err[g]       = (r_state == ST_ERROR);
`ifdef GLITC_CFG_AUTORETRY_EN
    assign w_retry[g]     = r_retry;
`else
    assign w_retry[g]     = 1'b0;
`endif
  end

endmodule

// File: tb/tb_glitc_config_ctrl.sv
// Self-checking bench for glitc_config_ctrl: timeline-based channel model plus directed literal checks.
module tb_glitc_config_ctrl;

  localparam int P    = 64;
  localparam int I    = 32;
  localparam int TB   = 8;
  localparam int TMAX = (1 << TB) - 1;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_READY = 2;
  localparam int M_ERR   = 3;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] done_i;
  logic [3:0] init_b_i;
  logic [3:0] program_b_o;
  logic [3:0] init_b_oe_o;
  logic [3:0] gready_o;

  glitc_config_ctrl_if bus_if ();

  glitc_config_ctrl #(
    .PROG_CYCLES (P),
    .INIT_CYCLES (I),
    .TIMEOUT_BITS(TB)
  ) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .bus        (bus_if),
    .done_i     (done_i),
    .init_b_i   (init_b_i),
    .program_b_o(program_b_o),
    .init_b_oe_o(init_b_oe_o),
    .gready_o   (gready_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_n    = 0;
  int pb_low[4];
  int oe_low[4];
  bit chk_on   = 1'b0;

  // Model: each channel is idle / running (age = cycles since PROGRAM_B fell) / ready / error.
  int         m_mode[4];
  int         m_age[4];
  bit         m_retry[4];
  bit         served;
  logic [3:0] pend_start, pend_abort;
  logic [3:0] d1, d2, i1, i2;
  logic       e_ack;
  logic [3:0] e_pb, e_oe, e_gr;
  logic [31:0] e_dat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_outputs();
    for (int c = 0; c < 4; c++) begin
      e_pb[c] = !(m_mode[c] == M_RUN && m_age[c] < P);
      e_oe[c] = (m_mode[c] == M_RUN && m_age[c] < P + I);
      e_gr[c] = (m_mode[c] == M_READY);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin
      m_mode[c]  = M_IDLE;
      m_age[c]   = 0;
      m_retry[c] = 1'b0;
    end
    served     = 1'b0;
    pend_start = 4'h0;
    pend_abort = 4'h0;
    d1 = 4'h0; d2 = 4'h0; i1 = 4'h0; i2 = 4'h0;
    e_ack = 1'b0;
    e_dat = 32'h0;
    model_outputs();
  endtask

  task automatic model_step();
    logic [3:0] gv, bv, ev, rv, ds;
    bit acked;
    for (int c = 0; c < 4; c++) begin
      gv[c] = (m_mode[c] == M_READY);
      bv[c] = (m_mode[c] == M_RUN);
      ev[c] = (m_mode[c] == M_ERR);
      rv[c] = m_retry[c];
    end
    e_dat = {8'h00, rv, i2, d2, ev, bv, gv};
    ds = d2;
    for (int c = 0; c < 4; c++) begin
      if (pend_abort[c]) begin
        m_mode[c]  = M_IDLE;
        m_retry[c] = 1'b0;
      end else if (pend_start[c]) begin
        m_mode[c]  = M_RUN;
        m_age[c]   = 0;
        m_retry[c] = 1'b0;
      end else if (m_mode[c] == M_RUN) begin
        if (m_age[c] >= P + I && ds[c]) begin
          m_mode[c] = M_READY;
        end else if (m_age[c] == P + I + TMAX - 1) begin
`ifdef GLITC_CFG_AUTORETRY_EN
          if (!m_retry[c]) begin
            m_retry[c] = 1'b1;
            m_age[c]   = 0;
          end else begin
            m_mode[c] = M_ERR;
          end
`else
          m_mode[c] = M_ERR;
`endif
        end else begin
          m_age[c]++;
        end
      end else if (m_mode[c] == M_READY && !ds[c]) begin
        m_mode[c] = M_ERR;
      end
    end
    d2 = d1; d1 = done_i;
    i2 = i1; i1 = init_b_i;
    if (bus_if.cyc_i && bus_if.stb_i) begin
      acked  = !served;
      served = 1'b1;
    end else begin
      acked  = 1'b0;
      served = 1'b0;
    end
    e_ack      = acked;
    pend_start = (acked && bus_if.we_i) ? bus_if.dat_i[3:0] : 4'h0;
    pend_abort = (acked && bus_if.we_i) ? bus_if.dat_i[7:4] : 4'h0;
    model_outputs();
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n && chk_on) begin
      chk("ack",       32'(bus_if.ack_o), 32'(e_ack));
      chk("program_b", 32'(program_b_o),  32'(e_pb));
      chk("init_b_oe", 32'(init_b_oe_o),  32'(e_oe));
      chk("gready",    32'(gready_o),     32'(e_gr));
      chk("status",    bus_if.dat_o,      e_dat);
    end
  end

  task automatic tick();
    @(negedge clk);
    cyc_n++;
    for (int c = 0; c < 4; c++) begin
      if (!program_b_o[c]) pb_low[c]++;
      if (init_b_oe_o[c])  oe_low[c]++;
    end
  endtask

  task automatic clr_cnt();
    for (int c = 0; c < 4; c++) begin
      pb_low[c] = 0;
      oe_low[c] = 0;
    end
  endtask

  task automatic bus_xfer(input bit w, input logic [31:0] d, input int hold);
    int n;
    n = 0;
    tick();
    bus_if.cyc_i = 1'b1;
    bus_if.stb_i = 1'b1;
    bus_if.we_i  = w;
    bus_if.dat_i = d;
    do begin
      tick();
      n++;
    end while (!bus_if.ack_o && n < 8);
    chk("ack_latency", 32'(n), 32'd1);
    repeat (hold) tick();
    bus_if.cyc_i = 1'b0;
    bus_if.stb_i = 1'b0;
    bus_if.we_i  = 1'b0;
    bus_if.dat_i = 32'h0;
  endtask

  initial begin
    int t0;
    bus_if.cyc_i = 1'b0;
    bus_if.stb_i = 1'b0;
    bus_if.we_i  = 1'b0;
    bus_if.dat_i = 32'h0;
    done_i   = 4'h0;
    init_b_i = 4'h0;
    clr_cnt();
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    chk_on = 1'b1;
    tick();
    chk("rst_program_b", 32'(program_b_o), 32'hF);
    chk("rst_gready",    32'(gready_o),    32'h0);
    chk("rst_status",    bus_if.dat_o,     32'h0);

    // Asynchronous reset in the middle of a PROGRAM_B pulse.
    bus_xfer(1'b1, 32'h1, 0);
    repeat (10) tick();
    chk("t1_mid_prog", 32'(program_b_o), 32'hE);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_async_program_b", 32'(program_b_o), 32'hF);
    chk("t1_async_init_oe",   32'(init_b_oe_o), 32'h0);
    chk("t1_async_gready",    32'(gready_o),    32'h0);
    chk("t1_async_status",    bus_if.dat_o,     32'h0);
    tick();
    tick();
    #2 rst_n = 1'b1;
    tick();

    // Nominal configuration of channel 2.
    clr_cnt();
    bus_xfer(1'b1, 32'h4, 0);
    for (int k = 0; k < 4 && !init_b_oe_o[2]; k++) tick();
    for (int k = 0; k < 200 && init_b_oe_o[2]; k++) tick();
    chk("t2_in_load", 32'(init_b_oe_o[2]), 32'h0);
    done_i[2] = 1'b1;
    tick();
    tick();
    chk("t2_gready_early", 32'(gready_o[2]), 32'h0);
    tick();
    chk("t2_gready_3cyc",  32'(gready_o[2]), 32'h1);
    chk("t2_pb_low_len",   32'(pb_low[2]),   32'd64);
    chk("t2_oe_len",       32'(oe_low[2]),   32'd96);
    tick();
    tick();
    chk("t2_status", bus_if.dat_o, 32'h0000_4004);

    // DONE never arrives on channel 0: LOAD times out.
    bus_xfer(1'b1, 32'h1, 0);
    for (int k = 0; k < 4 && program_b_o[0]; k++) tick();
    chk("t3_pb_low", 32'(program_b_o[0]), 32'h0);
    t0 = cyc_n;
    for (int k = 0; k < 1000 && !bus_if.dat_o[8]; k++) tick();
`ifdef GLITC_CFG_AUTORETRY_EN
    chk("t3_timeout_elapsed", 32'(cyc_n - t0), 32'd703);
    chk("t3_retry_used",      32'(bus_if.dat_o[20]), 32'h1);
`else
    chk("t3_timeout_elapsed", 32'(cyc_n - t0), 32'd352);
`endif
    chk("t3_error_bits", 32'(bus_if.dat_o[11:8]), 32'h1);

    // Abort and start together during LOAD: abort wins, no new PROGRAM_B pulse.
    bus_xfer(1'b1, 32'h1, 0);
    for (int k = 0; k < 4 && !init_b_oe_o[0]; k++) tick();
    for (int k = 0; k < 200 && init_b_oe_o[0]; k++) tick();
    chk("t4_in_load", 32'(init_b_oe_o[0]), 32'h0);
    repeat (20) tick();
    clr_cnt();
    bus_xfer(1'b1, 32'h11, 0);
    repeat (100) tick();
    chk("t4_no_prog_pulse", 32'(pb_low[0]), 32'h0);
    chk("t4_busy_err",      32'(bus_if.dat_o[11:4]), 32'h0);
    chk("t4_gready",        32'(gready_o), 32'h4);

    // All four started together, DONE staggered by 5 cycles.
    done_i = 4'h0;
    repeat (5) tick();
    bus_xfer(1'b1, 32'hF, 0);
    for (int k = 0; k < 4 && program_b_o != 4'h0; k++) tick();
    chk("t5_all_prog", 32'(program_b_o), 32'h0);
    for (int k = 0; k < 200 && init_b_oe_o != 4'h0; k++) tick();
    chk("t5_all_load", 32'(init_b_oe_o), 32'h0);
    done_i[0] = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      tick();
      if (k == 2)  chk("t5_step0_pre", 32'(gready_o), 32'h0);
      if (k == 3)  chk("t5_step1",     32'(gready_o), 32'h1);
      if (k == 7)  chk("t5_step1_hold",32'(gready_o), 32'h1);
      if (k == 8)  chk("t5_step3",     32'(gready_o), 32'h3);
      if (k == 12) chk("t5_step3_hold",32'(gready_o), 32'h3);
      if (k == 13) chk("t5_step7",     32'(gready_o), 32'h7);
      if (k == 17) chk("t5_step7_hold",32'(gready_o), 32'h7);
      if (k == 18) chk("t5_stepF",     32'(gready_o), 32'hF);
      if (k == 5)  done_i[1] = 1'b1;
      if (k == 10) done_i[2] = 1'b1;
      if (k == 15) done_i[3] = 1'b1;
    end

    // DONE drops on channel 1 while READY.
    done_i[1] = 1'b0;
    tick();
    tick();
    chk("t6_gready_hold", 32'(gready_o), 32'hF);
    tick();
    chk("t6_gready_drop", 32'(gready_o), 32'hD);
    tick();
    chk("t6_error_bit", 32'(bus_if.dat_o[11:8]), 32'h2);

    // Held read is acked once and changes nothing; held write restarts channel 3.
    bus_xfer(1'b0, 32'h0F, 3);
    chk("t7_read_noeffect", 32'(gready_o), 32'hD);
    bus_xfer(1'b1, 32'h8, 3);
    repeat (5) tick();
    chk("t7_restart_ch3", 32'(program_b_o), 32'h7);
    repeat (5) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
